adc_acc_unit: RTL



---
 rtl/adc_acc_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/adc_acc_unit.sv
// adc_acc_unit: accumulate stage around an external 32-bit add/subtract unit.
// Drives the adder from the accumulator and the operand stream, folds each
// accepted result back into the accumulator, collects sticky carry/overflow
// and presents the final value on a valid/ready result port.
// Optional feature: define ADC_ACC_SAT_EN to saturate the accumulator on
// signed overflow instead of wrapping.
module adc_acc_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic [31:0] init,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_data,
    input  logic        b_sub,
    output logic [31:0] adc_A,
    output logic [31:0] adc_B,
    output logic        adc_C0,
    input  logic [32:0] adc_S,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_c,
    output logic        res_v,
    output logic        res_z,
    output logic        res_n,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_acc;
    logic [7:0]  r_cnt;
    logic [7:0]  r_len;
    logic        r_c;
    logic        r_v;
    logic        r_b_ready;
    logic        r_res_valid;
    logic        r_busy;

    logic        w_ovf;
    logic [31:0] w_acc_nxt;
    logic [7:0]  w_cnt_nxt;

    assign adc_A     = r_acc;
    assign adc_B     = b_data;
    assign adc_C0    = b_sub;
    assign b_ready   = r_b_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign res_data  = r_acc;
    assign res_c     = r_c;
    assign res_v     = r_v;
    assign res_z     = (r_acc == 32'd0);
    assign res_n     = r_acc[31];
    assign w_cnt_nxt = r_cnt + 8'd1;

    // Signed overflow of the adder result and the value folded back into acc
    always_comb begin
        w_ovf = (adc_S[31] != r_acc[31]) &&
                (b_sub ? (r_acc[31] != b_data[31]) : (r_acc[31] == b_data[31]));
`ifdef ADC_ACC_SAT_EN
        w_acc_nxt = w_ovf ? (r_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : adc_S[31:0];
`else
        w_acc_nxt = adc_S[31:0];
`endif
    end

    // Run control FSM with registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= 32'd0;
            r_cnt       <= 8'd0;
            r_len       <= 8'd0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_b_ready   <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_acc  <= init;
                    r_len  <= len;
                    r_cnt  <= 8'd0;
                    r_c    <= 1'b0;
                    r_v    <= 1'b0;
                    r_busy <= 1'b1;
                    if (len != 8'd0) begin
                        r_state   <= ACC;
                        r_b_ready <= 1'b1;
                    end else begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                ACC: if (b_valid) begin
                    r_acc <= w_acc_nxt;
                    r_c   <= r_c | adc_S[32];
                    r_v   <= r_v | w_ovf;
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_len) begin
                        r_state     <= DONE;
                        r_b_ready   <= 1'b0;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: if (res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_b_ready   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
